// File: rtl/i2s_codec_intf.sv
// I2S serial port to the CS4272: clock generation, codec reset, stereo RX deserializer and TX serializer.
// Define I2S_LOOPBACK_EN to transmit the received pair instead of lft_out/rht_out.
module i2s_codec_intf #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              RST_n,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              RSTn,
  input  logic              SDout,
  output logic              SDin,
  output logic [DATA_W-1:0] lft_in,
  output logic [DATA_W-1:0] rht_in,
  output logic              vld,
  input  logic [DATA_W-1:0] lft_out,
  input  logic [DATA_W-1:0] rht_out
);

  localparam logic [4:0] LastIdx = 5'(DATA_W);

  logic [9:0]        cnt_q;
  logic              rstn_q;
  logic              vld_q;
  logic              sdin_q;
  logic [DATA_W-2:0] rx_sh_q;
  logic [DATA_W-1:0] lft_hold_q;
  logic [DATA_W-1:0] lft_q;
  logic [DATA_W-1:0] rht_q;
  logic [DATA_W-1:0] tx_l_q;
  logic [DATA_W-1:0] tx_r_q;

  logic [4:0]        idx;
  logic [5:0]        nxt_slot;
  logic [4:0]        nxt_idx;
  logic              rx_bit;
  logic              rx_last;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] tx_mask;
  logic              tx_bit;

  assign idx      = cnt_q[8:4];
  // Slot/bit position that the SCLK-falling update is about to enter.
  assign nxt_slot = cnt_q[9:4] + 6'd1;
  assign nxt_idx  = nxt_slot[4:0];
  assign rx_bit   = (cnt_q[3:0] == 4'b0111) && (idx >= 5'd1) && (idx <= LastIdx);
  assign rx_last  = rx_bit && (idx == LastIdx);
  assign rx_word  = {rx_sh_q, SDout};

  always_comb begin
    tx_buf  = nxt_slot[5] ? tx_r_q : tx_l_q;
    tx_mask = '0;
    tx_bit  = 1'b0;
    if ((nxt_idx != 5'd0) && (nxt_idx <= LastIdx)) begin
      tx_mask = {{(DATA_W-1){1'b0}}, 1'b1} << (LastIdx - nxt_idx);
      tx_bit  = |(tx_buf & tx_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_n) begin
      cnt_q      <= '0;
      rstn_q     <= 1'b0;
      vld_q      <= 1'b0;
      sdin_q     <= 1'b0;
      rx_sh_q    <= '0;
      lft_hold_q <= '0;
      lft_q      <= '0;
      rht_q      <= '0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
    end else begin
      cnt_q <= cnt_q + 10'd1;
      if (cnt_q == 10'h3FF) begin
        rstn_q <= 1'b1;
`ifdef I2S_LOOPBACK_EN
        tx_l_q <= lft_q;
        tx_r_q <= rht_q;
`else
        tx_l_q <= lft_out;
        tx_r_q <= rht_out;
`endif
      end
      if (rx_bit) begin
        rx_sh_q <= rx_word[DATA_W-2:0];
      end
      if (rx_last && !cnt_q[9]) begin
        lft_hold_q <= rx_word;
      end
      // rstn_q only rises at a frame boundary, so it doubles as the "whole frame seen" flag.
      vld_q <= rx_last && cnt_q[9] && rstn_q;
      if (rx_last && cnt_q[9] && rstn_q) begin
        lft_q <= lft_hold_q;
        rht_q <= rx_word;
      end
      if (cnt_q[3:0] == 4'b1111) begin
        sdin_q <= tx_bit;
      end
    end
  end

  assign MCLK   = cnt_q[1];
  assign SCLK   = cnt_q[3];
  assign LRCLK  = cnt_q[9];
  assign RSTn   = rstn_q;
  assign SDin   = sdin_q;
  assign vld    = vld_q;
  assign lft_in = lft_q;
  assign rht_in = rht_q;

endmodule
